// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register: manual modes (which
// double as the per-bit mux selects), burst FSM states and burst directions.
package usr_pkg;

    // Manual modes; the same encoding drives the bit-slice next-state mux.
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Burst engine states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Burst directions.
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Map a latched burst direction onto the shift select it drives.
    function automatic logic [1:0] dir_to_sel(input logic dir);
        logic [1:0] sel;
        if (dir == DIR_LEFT) begin
            sel = MODE_SHL;
        end else begin
            sel = MODE_SHR;
        end
        return sel;
    endfunction

endpackage

// File: rtl/usr_cell.sv
// One bit slice of the universal shift register: a 4:1 next-state mux
// (hold, bit from the MSB side, bit from the LSB side, parallel data)
// feeding a synchronously reset flop.
module usr_cell
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel_i,
    input  logic       from_msb_i,
    input  logic       from_lsb_i,
    input  logic       par_i,
    output logic       q_o
);

    logic q_q;
    logic q_d;

    // Select this bit's next value from the shared mode select.
    always_comb begin
        q_d = q_q;
        case (sel_i)
            MODE_HOLD: q_d = q_q;
            MODE_SHR:  q_d = from_msb_i;
            MODE_SHL:  q_d = from_lsb_i;
            MODE_LOAD: q_d = par_i;
            default:   q_d = q_q;
        endcase
    end

    // Storage flop with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register. Manual hold/shift/load operation in
// IDLE, plus a burst engine that shifts a programmed (clamped) number of
// positions in a latched direction and reports busy and a one-cycle done.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] par_out,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [1:0]       sel_s;
    logic [CNT_W-1:0] len_eff_s;
    logic [WIDTH-1:0] shreg_s;

    // Clamp the requested burst length to the register width.
    always_comb begin
        if (burst_len > WIDTH_C) begin
            len_eff_s = WIDTH_C;
        end else begin
            len_eff_s = burst_len;
        end
    end

    // Burst FSM next state, counter/direction update and the bit-slice
    // select shared by manual and burst operation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        sel_s   = MODE_HOLD;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A start drops any manual operation on the same cycle.
                    dir_d = dir;
                    cnt_d = len_eff_s;
                    if (burst_len == ZERO_C) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else if (en) begin
                    sel_s = mode;
                end else begin
                    sel_s = MODE_HOLD;
                end
            end
            ST_SHIFT: begin
                sel_s = dir_to_sel(dir_q);
                cnt_d = cnt_q - ONE_C;
                if (cnt_q == ONE_C) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, counter and direction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= ZERO_C;
            dir_q   <= DIR_RIGHT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    // Bit slices; the end cells take their fill from the serial inputs.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic from_msb_s;
        logic from_lsb_s;
        if (i == WIDTH - 1) begin : g_top
            assign from_msb_s = ser_in_r;
        end else begin : g_top_mid
            assign from_msb_s = shreg_s[i+1];
        end
        if (i == 0) begin : g_bot
            assign from_lsb_s = ser_in_l;
        end else begin : g_bot_mid
            assign from_lsb_s = shreg_s[i-1];
        end
        usr_cell u_cell (
            .clk        (clk),
            .rst        (rst),
            .sel_i      (sel_s),
            .from_msb_i (from_msb_s),
            .from_lsb_i (from_lsb_s),
            .par_i      (par_in[i]),
            .q_o        (shreg_s[i])
        );
    end

    assign par_out   = shreg_s;
    assign ser_out_r = shreg_s[0];
    assign ser_out_l = shreg_s[WIDTH-1];
    assign busy      = (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);

endmodule
